// File: rtl/processing_hw_frame_accum_if.sv
// Handshake bundle between the multiplier-side upstream, the frame accumulator
// and the downstream result consumer.
interface processing_hw_frame_accum_if #(
   parameter int PROD_W = 23,
   parameter int OUT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic              mul_ce;
   logic              clear;
   logic [PROD_W-1:0] prod;
   logic [OUT_W-1:0]  out_data;
   logic              out_sat;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_valid, clear, prod, out_ready,
      input  in_ready, mul_ce, out_data, out_sat, out_valid
   );

   modport slave (
      input  in_valid, clear, prod, out_ready,
      output in_ready, mul_ce, out_data, out_sat, out_valid
   );
endinterface

// File: rtl/processing_hw_frame_accum.sv
// Frame accumulator behind a ce-gated pipelined multiplier: sums FRAME_LEN
// products, rounds, shifts and saturates, and stalls the pipe on backpressure.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_ACCUM | no result pending; products are consumed as they arrive
// S_HOLD  | result presented on out_valid, waiting for out_ready
module processing_hw_frame_accum #(
   parameter int PROD_W    = 23,
   parameter int MUL_LAT   = 3,
   parameter int FRAME_LEN = 16,
   parameter int ACC_W     = 32,
   parameter int SHIFT     = 8,
   parameter int OUT_W     = 16
) (
   input  logic clk,
   input  logic reset,
   processing_hw_frame_accum_if.slave bus
);

   localparam int CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [ACC_W:0] HALF    = (SHIFT > 0) ? ((ACC_W+1)'(1) << SHIFT_M1) : '0;
   localparam logic [ACC_W:0] MAX_OUT = (ACC_W+1)'({OUT_W{1'b1}});
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      S_ACCUM = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [MUL_LAT-1:0]  vpipe;
   logic [CNT_W-1:0]    cnt;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    sum;
   logic [ACC_W:0]      rnd;
   logic [OUT_W-1:0]    data_q;
   logic                sat_q;
   logic                ce;
   logic                consume;
   logic                last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_ACCUM;
      end else begin
         state <= state_nx;
      end
   end

   // A clear edge suppresses consumption, so it can never complete a frame.
   always_comb begin
      ce       = !(state == S_HOLD && !bus.out_ready);
      consume  = ce && vpipe[MUL_LAT-1] && !bus.clear;
      last     = consume && (cnt == CNT_LAST);
      state_nx = state;
      if (last) begin
         state_nx = S_HOLD;
      end else if (state == S_HOLD && bus.out_ready) begin
         state_nx = S_ACCUM;
      end
   end

   always_comb begin
      sum = ((cnt == '0) ? '0 : acc) + ACC_W'(bus.prod);
      rnd = ({1'b0, sum} + HALF) >> SHIFT;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vpipe  <= '0;
         cnt    <= '0;
         acc    <= '0;
         data_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         if (bus.clear) begin
            vpipe <= '0;
            cnt   <= '0;
            acc   <= '0;
         end else if (ce) begin
            vpipe <= MUL_LAT'({vpipe, bus.in_valid});
            if (consume) begin
               if (last) begin
                  cnt <= '0;
               end else begin
                  acc <= sum;
                  cnt <= cnt + CNT_W'(1);
               end
            end
         end
         if (last) begin
            data_q <= (rnd > MAX_OUT) ? '1 : rnd[OUT_W-1:0];
            sat_q  <= (rnd > MAX_OUT);
         end
      end
   end

   assign bus.mul_ce    = ce;
   assign bus.in_ready  = ce;
   assign bus.out_valid = (state == S_HOLD);
   assign bus.out_data  = data_q;
   assign bus.out_sat   = sat_q;

endmodule
